// File: rtl/nn_uart_pkg.sv
// Shared definitions for the UART-to-NN byte framing path: FSM states and
// default framing constants.
package nn_uart_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PAYLOAD = 2'b01,
    CHECK   = 2'b10,
    HOLD    = 2'b11
  } state_t;

  localparam logic [7:0]  DEF_SYNC_BYTE    = 8'hA5;
  // 10 bit-times at 9600 baud from a 50 MHz clock
  localparam int unsigned DEF_TIMEOUT_CLKS = 52080;
  localparam int unsigned TIMER_W          = 20;

endpackage

// File: rtl/uart_frame_decoder_if.sv
// Byte-in / frame-out bundle between the UART receiver, the frame decoder
// and the NN input loader. master = decoder side.
interface uart_frame_decoder_if #(
  parameter int unsigned N_BYTES = 8
);
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic [8*N_BYTES-1:0] frame_data;
  logic                 frame_valid;
  logic                 frame_ready;
  logic                 busy;
  logic                 chk_err;
  logic                 timeout_err;
  logic                 overrun_err;

  modport master (
    input  rx_data, rx_valid, frame_ready,
    output frame_data, frame_valid, busy, chk_err, timeout_err, overrun_err
  );

  modport slave (
    output rx_data, rx_valid, frame_ready,
    input  frame_data, frame_valid, busy, chk_err, timeout_err, overrun_err
  );
endinterface

// File: rtl/uart_byte_timeout.sv
// Inter-byte watchdog: 20-bit up counter that clears on demand and flags
// the cycle in which it sits at LIMIT-1 while still counting.
module uart_byte_timeout
  import nn_uart_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_TIMEOUT_CLKS
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign expire = inc && (count == LAST);

endmodule

// File: rtl/uart_frame_decoder.sv
// Sync-hunting frame decoder: collects N_BYTES payload bytes after SYNC_BYTE,
// verifies an XOR checksum and holds the frame until the loader accepts it.
module uart_frame_decoder
  import nn_uart_pkg::*;
#(
  parameter int unsigned N_BYTES      = 8,
  parameter logic [7:0]  SYNC_BYTE    = DEF_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
  input logic                 clk,
  input logic                 rst,
  uart_frame_decoder_if.master bus
);

  localparam int unsigned     IDX_W    = $clog2(N_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [7:0]           csum;
  logic [8*N_BYTES-1:0] frame_q;
  logic                 frame_valid_q;
  logic                 busy_q;
  logic                 chk_err_q;
  logic                 timeout_err_q;
  logic                 overrun_err_q;
  logic                 counting;
  logic                 timer_clr;
  logic                 expire;

  // Timer runs only while a frame is in flight; a byte always restarts it.
  assign counting  = (state == PAYLOAD) || (state == CHECK);
  assign timer_clr = !counting || bus.rx_valid;

  uart_byte_timeout #(
    .LIMIT(TIMEOUT_CLKS)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .inc    (counting),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      csum          <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      chk_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      chk_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
            state  <= PAYLOAD;
            idx    <= '0;
            csum   <= '0;
            busy_q <= 1'b1;
          end
        end
        PAYLOAD: begin
          if (bus.rx_valid) begin
            frame_q[idx*8 +: 8] <= bus.rx_data;
            csum                <= csum ^ bus.rx_data;
            idx                 <= idx + IDX_W'(1);
            if (idx == LAST_IDX) begin
              state <= CHECK;
            end
          end else if (expire) begin
            timeout_err_q <= 1'b1;
            state         <= IDLE;
            busy_q        <= 1'b0;
          end
        end
        CHECK: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == csum) begin
              state         <= HOLD;
              frame_valid_q <= 1'b1;
            end else begin
              chk_err_q <= 1'b1;
              state     <= IDLE;
              busy_q    <= 1'b0;
            end
          end else if (expire) begin
            timeout_err_q <= 1'b1;
            state         <= IDLE;
            busy_q        <= 1'b0;
          end
        end
        HOLD: begin
          // A byte landing in the acceptance cycle is still an overrun.
          if (bus.rx_valid) begin
            overrun_err_q <= 1'b1;
          end
          if (bus.frame_ready) begin
            frame_valid_q <= 1'b0;
            state         <= IDLE;
            busy_q        <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.frame_data  = frame_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.busy        = busy_q;
  assign bus.chk_err     = chk_err_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder (N_BYTES=4, TIMEOUT_CLKS=1000) with a
// queue-based frame model checked every cycle plus literal expectations.
module tb_uart_frame_decoder;

  localparam int unsigned NB = 4;
  localparam int unsigned TO = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_frame_decoder_if #(.N_BYTES(NB)) bus ();

  uart_frame_decoder #(
    .N_BYTES      (NB),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: collected bytes in a queue, a pending-frame flag and a
  // count of silent cycles since the last byte of the frame in progress.
  byte unsigned mq[$];
  bit           m_in_frame, m_pending;
  int           m_silent;
  logic [31:0]  m_data;
  bit           m_chk, m_to, m_ov;

  // Observations of the DUT used by the literal checks.
  int          acc_cnt = 0, valid_cycles = 0, chk_cnt = 0, to_cnt = 0, ov_cnt = 0;
  logic [31:0] last_acc = '0;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_data = '0;

  always @(posedge clk) begin
    byte unsigned x;
    if (!rst && prev_valid && bus.frame_ready) begin
      acc_cnt++;
      last_acc = prev_data;
    end
    m_chk = 0; m_to = 0; m_ov = 0;
    if (rst) begin
      m_in_frame = 0; m_pending = 0; m_silent = 0; mq.delete();
    end else if (m_pending) begin
      if (bus.rx_valid) m_ov = 1;
      if (bus.frame_ready) m_pending = 0;
    end else if (m_in_frame) begin
      if (bus.rx_valid) begin
        m_silent = 0;
        if (mq.size() == NB) begin
          x = 0;
          foreach (mq[k]) x ^= mq[k];
          m_in_frame = 0;
          if (bus.rx_data == x) begin
            m_pending = 1;
            m_data = '0;
            foreach (mq[k]) m_data[8*k +: 8] = mq[k];
          end else begin
            m_chk = 1;
          end
        end else begin
          mq.push_back(bus.rx_data);
        end
      end else begin
        m_silent++;
        if (m_silent == TO) begin
          m_to = 1;
          m_in_frame = 0;
        end
      end
    end else if (bus.rx_valid && bus.rx_data == 8'hA5) begin
      m_in_frame = 1; m_silent = 0; mq.delete();
    end

    #2;
    check("frame_valid", bus.frame_valid, m_pending);
    check("busy", bus.busy, m_in_frame || m_pending);
    check("chk_err", bus.chk_err, m_chk);
    check("timeout_err", bus.timeout_err, m_to);
    check("overrun_err", bus.overrun_err, m_ov);
    if (m_pending) check("frame_data", bus.frame_data, m_data);

    if (bus.frame_valid) valid_cycles++;
    chk_cnt += int'(bus.chk_err);
    to_cnt  += int'(bus.timeout_err);
    ov_cnt  += int'(bus.overrun_err);
    prev_valid = bus.frame_valid;
    prev_data  = bus.frame_data;
  end

  task automatic send_seq(input byte unsigned s[$]);
    foreach (s[i]) begin
      bus.rx_data  = s[i];
      bus.rx_valid = 1'b1;
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_frame_valid"}, bus.frame_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_errs"}, {bus.chk_err, bus.timeout_err, bus.overrun_err}, 0);
    check({tag, "_frame_data"}, bus.frame_data, 0);
  endtask

  initial begin
    byte unsigned s[$];
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    bus.frame_ready = 1'b1;
    idle(3);
    check_all_zero("reset");
    rst = 1'b0;

    s = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_seq(s); idle(3);
    check("s1_accepted", acc_cnt, 1);
    check("s1_data", last_acc, 32'h04030201);
    check("s1_valid_cycles", valid_cycles, 1);
    check("s1_errs", chk_cnt + to_cnt + ov_cnt, 0);

    s = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_seq(s); idle(3);
    check("s2_chk_err", chk_cnt, 1);
    check("s2_no_frame", valid_cycles, 1);
    check("s2_busy", bus.busy, 0);

    s = '{8'h00, 8'h7F, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_seq(s); idle(3);
    check("s3_accepted", acc_cnt, 2);
    check("s3_data", last_acc, 32'h44332211);

    s = '{8'hA5, 8'hA5, 8'h00, 8'hA5, 8'h00, 8'h00};
    send_seq(s); idle(3);
    check("sync_as_data", last_acc, 32'h00A500A5);

    // Sync in the acceptance cycle is an overrun; the next one is recognised.
    s = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04,
          8'hA5, 8'hA5, 8'h09, 8'h08, 8'h07, 8'h06, 8'h00};
    send_seq(s); idle(3);
    check("b2b_overrun", ov_cnt, 1);
    check("b2b_accepted", acc_cnt, 5);
    check("b2b_data", last_acc, 32'h06070809);

    bus.frame_ready = 1'b0;
    s = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_seq(s); idle(2);
    s = '{8'hA5};
    send_seq(s); idle(2);
    check("s4_overrun", ov_cnt, 2);
    check("s4_valid_held", bus.frame_valid, 1);
    check("s4_data_held", bus.frame_data, 32'h04030201);
    bus.frame_ready = 1'b1;
    @(posedge clk); #2;
    check("s4_valid_drop", bus.frame_valid, 0);
    @(negedge clk);
    check("s4_accepted", acc_cnt, 6);

    // Byte arriving exactly on the last allowed cycle still wins.
    s = '{8'hA5, 8'h10};
    send_seq(s); idle(TO - 1);
    s = '{8'h20, 8'h30, 8'h40, 8'h40};
    send_seq(s); idle(3);
    check("edge_no_timeout", to_cnt, 0);
    check("edge_data", last_acc, 32'h40302010);

    s = '{8'hA5, 8'h01, 8'h02};
    send_seq(s); idle(TO - 1);
    check("s5_no_early_timeout", to_cnt, 0);
    idle(3);
    check("s5_timeout", to_cnt, 1);
    check("s5_idle", bus.busy, 0);
    s = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_seq(s); idle(3);
    check("s5_recover", acc_cnt, 8);
    check("s5_data", last_acc, 32'h04030201);

    s = '{8'hA5, 8'h01};
    send_seq(s);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("s6_reset");
    s = '{8'hA5, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    send_seq(s); idle(3);
    check("s6_accepted", acc_cnt, 9);
    check("s6_data", last_acc, 32'hDDCCBBAA);
    check("final_chk_cnt", chk_cnt, 1);
    check("final_to_cnt", to_cnt, 1);
    check("final_ov_cnt", ov_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
